// File: rtl/bz_sequencer_pkg.sv
// Shared types and constants for the buzzer melody sequencer.
// Note byte layout: [7:4] duration code, [3:0] pitch code.
package bz_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STROBE,
        ST_NOTE,
        ST_GAP
    } state_t;

    localparam int DUR_MSB   = 7;
    localparam int DUR_LSB   = 4;
    localparam int PITCH_MSB = 3;
    localparam int PITCH_LSB = 0;

    localparam logic [3:0] PITCH_REST  = 4'h0;
    localparam logic [7:0] BZ_VAL_IDLE = 8'h00;

    localparam int CNT_W = 24;

    function automatic logic [3:0] note_dur(input logic [7:0] note);
        return note[DUR_MSB:DUR_LSB];
    endfunction

    // A rest still gets a strobe and full timing; the player makes it silent.
    function automatic logic note_is_rest(input logic [7:0] note);
        return note[PITCH_MSB:PITCH_LSB] == PITCH_REST;
    endfunction

endpackage

// File: rtl/bz_seq_timer.sv
// Loadable down-counter shared by the STROBE, NOTE and GAP phases.
// Loading N-1 makes expire rise on the N-th cycle after the load edge.
module bz_seq_timer
    import bz_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/bz_sequencer.sv
// Plays a preloaded note score on the io_control buzzer interface, timing
// strobe, note and inter-note gap; supports looping and abort on stop.
module bz_sequencer
    import bz_sequencer_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int TICK_CYCLES = 1000000,
    parameter int WR_HOLD     = 2,
    parameter int GAP_CYCLES  = 100000
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   len,
    input  logic          loop,
    input  logic          play,
    input  logic          stop,
    output logic          bz_wr,
    output logic [7:0]    bz_val,
    output logic          busy,
    output logic [AW-1:0] cur_idx,
    output logic          done
);

    localparam logic [CNT_W-1:0] TICK_VAL  = CNT_W'(TICK_CYCLES);
    localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [AW:0]      DEPTH_LEN = (AW + 1)'(DEPTH);

    if (longint'(TICK_CYCLES) * 16 > (longint'(1) << CNT_W) - 1 || TICK_CYCLES < 1 ||
        WR_HOLD < 1 || GAP_CYCLES < 0 || longint'(GAP_CYCLES) > (longint'(1) << CNT_W) ||
        DEPTH != (1 << AW)) begin : g_bad_params
        $error("bz_sequencer: parameter set does not fit the 24-bit timer or score size");
    end

    logic [7:0] score_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            score_q[wr_addr] <= wr_data;
        end
    end

    state_t           state_q, state_d, after_note;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    cur_idx_q, cur_idx_d;
    logic [7:0]       bz_val_q, bz_val_d;
    logic             bz_wr_q, bz_wr_d;
    logic             done_q, done_d;
    logic             tmr_load, tmr_expire;
    logic [CNT_W-1:0] tmr_val, note_len;
    logic [AW:0]      len_eff, idx_inc;
    logic             start_req, more_notes, note_end, abort;

    bz_seq_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    assign len_eff    = (len > DEPTH_LEN) ? DEPTH_LEN : len;
    assign idx_inc    = {1'b0, idx_q} + (AW + 1)'(1);
    assign more_notes = (idx_inc < len_eff);
    assign start_req  = play && !stop;
    assign abort      = stop && (state_q != ST_IDLE);
    assign note_len   = (CNT_W'(note_dur(bz_val_q)) + CNT_W'(1)) * TICK_VAL - CNT_W'(1);
    // With no gap configured, the end-of-note decision is taken straight from NOTE.
    assign note_end   = tmr_expire && ((state_q == ST_GAP) ||
                                       (state_q == ST_NOTE && GAP_CYCLES == 0));
    assign after_note = (more_notes || loop) ? ST_LOAD : ST_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_req && len_eff != '0) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_STROBE;
            ST_STROBE: if (tmr_expire) state_d = ST_NOTE;
            ST_NOTE:   if (tmr_expire) state_d = (GAP_CYCLES == 0) ? after_note : ST_GAP;
            ST_GAP:    if (tmr_expire) state_d = after_note;
            default:   state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        idx_d     = idx_q;
        cur_idx_d = cur_idx_q;
        bz_val_d  = bz_val_q;
        bz_wr_d   = 1'b0;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if (len_eff == '0) done_d = 1'b1;
                    else               idx_d  = '0;
                end
            end
            ST_LOAD: begin
                bz_val_d  = score_q[idx_q];
                cur_idx_d = idx_q;
                bz_wr_d   = 1'b1;
                tmr_load  = 1'b1;
                tmr_val   = WR_LOAD;
            end
            ST_STROBE: begin
                bz_wr_d = !tmr_expire;
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = note_len;
                end
            end
            ST_NOTE: begin
                if (tmr_expire && GAP_CYCLES != 0) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            default: ;
        endcase
        if (note_end) begin
            if (more_notes) begin
                idx_d = idx_inc[AW-1:0];
            end else if (loop) begin
                idx_d = '0;
            end else begin
                done_d   = 1'b1;
                bz_val_d = BZ_VAL_IDLE;
            end
        end
        // Abort silences the buzzer immediately and suppresses done.
        if (abort) begin
            bz_wr_d  = 1'b0;
            bz_val_d = BZ_VAL_IDLE;
            done_d   = 1'b0;
            tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= '0;
            cur_idx_q <= '0;
            bz_val_q  <= BZ_VAL_IDLE;
            bz_wr_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            cur_idx_q <= cur_idx_d;
            bz_val_q  <= bz_val_d;
            bz_wr_q   <= bz_wr_d;
            done_q    <= done_d;
        end
    end

    assign bz_wr   = bz_wr_q;
    assign bz_val  = bz_val_q;
    assign busy    = (state_q != ST_IDLE);
    assign cur_idx = cur_idx_q;
    assign done    = done_q;

endmodule
